// File: rtl/rv_wb_arbiter.sv
// Round-robin write-back arbiter: merges per-unit completion ports onto one register-file write port.
// Define RV_WB_ARB_BYPASS_EN for a combinational (zero-latency) write path instead of the registered one.
module rv_wb_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int XLEN      = 64,
  parameter int FLEN      = 32,
  localparam int MaxLen   = (XLEN > FLEN) ? XLEN : FLEN
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic [NUM_PORTS*6-1:0]      cmp_addr_i,
  input  logic [NUM_PORTS*MaxLen-1:0] cmp_data_i,
  input  logic [NUM_PORTS-1:0]        cmp_valid_i,
  output logic [NUM_PORTS-1:0]        cmp_ready_o,
  output logic [5:0]                  wr_addr_o,
  output logic [MaxLen-1:0]           wr_data_o,
  output logic                        wr_en_o,
  output logic [15:0]                 busy_cnt_o
);

  localparam int PtrW = $clog2(NUM_PORTS);
  localparam logic [PtrW:0] NumPortsW = (PtrW+1)'(NUM_PORTS);

  logic [PtrW-1:0]      rr_q, rr_d;
  logic [15:0]          busyCnt_q, busyCnt_d;
  logic [NUM_PORTS-1:0] grantVec;
  logic [PtrW-1:0]      winnerIdx;
  logic                 winnerFound;
  logic                 transfer;
  logic                 overflow;
  logic [3:0]           validCnt;
  logic [5:0]           selAddr;
  logic [MaxLen-1:0]    selData;
  logic [PtrW:0]        searchIdx;
  logic [PtrW:0]        nextPtr;

  // Search valid ports starting at rr_q with wrap; ready is held low while reset is asserted.
  always_comb begin
    grantVec    = '0;
    winnerIdx   = '0;
    winnerFound = 1'b0;
    searchIdx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      searchIdx = {1'b0, rr_q} + (PtrW+1)'(k);
      if (searchIdx >= NumPortsW) begin
        searchIdx = searchIdx - NumPortsW;
      end
      if (!winnerFound && cmp_valid_i[searchIdx[PtrW-1:0]]) begin
        winnerFound = 1'b1;
        winnerIdx   = searchIdx[PtrW-1:0];
      end
    end
    if (winnerFound && arst_ni) begin
      grantVec[winnerIdx] = 1'b1;
    end
  end

  assign cmp_ready_o = grantVec;
  assign transfer    = |grantVec;

  always_comb begin
    selAddr  = '0;
    selData  = '0;
    validCnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      validCnt = validCnt + 4'(cmp_valid_i[p]);
      if (grantVec[p]) begin
        selAddr = cmp_addr_i[p*6 +: 6];
        selData = cmp_data_i[p*MaxLen +: MaxLen];
      end
    end
  end

  // A cycle is busy when some valid port went unserved.
  always_comb begin
    overflow  = validCnt > {3'b000, transfer};
    busyCnt_d = busyCnt_q;
    if (overflow && (busyCnt_q != 16'hFFFF)) begin
      busyCnt_d = busyCnt_q + 16'd1;
    end
    nextPtr = {1'b0, winnerIdx} + {{PtrW{1'b0}}, 1'b1};
    if (nextPtr == NumPortsW) begin
      nextPtr = '0;
    end
    rr_d = transfer ? nextPtr[PtrW-1:0] : rr_q;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rr_q      <= '0;
      busyCnt_q <= '0;
    end else begin
      rr_q      <= rr_d;
      busyCnt_q <= busyCnt_d;
    end
  end

  assign busy_cnt_o = busyCnt_q;

`ifdef RV_WB_ARB_BYPASS_EN
  assign wr_addr_o = selAddr;
  assign wr_data_o = selData;
  assign wr_en_o   = transfer;
`else
  logic [5:0]        wrAddr_q, wrAddr_d;
  logic [MaxLen-1:0] wrData_q, wrData_d;
  logic              wrEn_q, wrEn_d;

  // Address and data only move on a transfer so idle cycles keep the last write visible.
  always_comb begin
    wrEn_d   = transfer;
    wrAddr_d = transfer ? selAddr : wrAddr_q;
    wrData_d = transfer ? selData : wrData_q;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
    end else begin
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
    end
  end

  assign wr_addr_o = wrAddr_q;
  assign wr_data_o = wrData_q;
  assign wr_en_o   = wrEn_q;
`endif

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Bench for rv_wb_arbiter: behavioural round-robin model checked every cycle plus directed literal checks.
module tb_rv_wb_arbiter;

  logic        clk = 1'b0;
  logic        arst_ni = 1'b0;
  logic [17:0] cmpAddr = '0;
  logic [191:0] cmpData = '0;
  logic [2:0]  cmpValid = '0;
  logic [2:0]  cmp_ready_o;
  logic [5:0]  wr_addr_o;
  logic [63:0] wr_data_o;
  logic        wr_en_o;
  logic [15:0] busy_cnt_o;

  int total = 0;
  int bad = 0;

  // Model state: pointer, last registered write and busy counter.
  int          mRr = 0;
  bit          mWrEn = 1'b0;
  logic [5:0]  mWrAddr = '0;
  logic [63:0] mWrData = '0;
  int          mBusy = 0;

  rv_wb_arbiter dut (
    .clk_i      (clk),
    .arst_ni    (arst_ni),
    .cmp_addr_i (cmpAddr),
    .cmp_data_i (cmpData),
    .cmp_valid_i(cmpValid),
    .cmp_ready_o(cmp_ready_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .wr_en_o    (wr_en_o),
    .busy_cnt_o (busy_cnt_o)
  );

  initial forever #5 clk = ~clk;

  function automatic int winnerOf(input logic [2:0] v, input int rr);
    for (int k = 0; k < 3; k++) begin
      if (v[(rr + k) % 3]) return (rr + k) % 3;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge arst_ni) begin : model
    int w;
    if (!arst_ni) begin
      mRr = 0; mWrEn = 1'b0; mWrAddr = '0; mWrData = '0; mBusy = 0;
    end else begin
      w = winnerOf(cmpValid, mRr);
      if ($countones(cmpValid) > ((w >= 0) ? 1 : 0) && mBusy < 65535) mBusy++;
      mWrEn = (w >= 0);
      if (w >= 0) begin
        mWrAddr = cmpAddr[w*6 +: 6];
        mWrData = cmpData[w*64 +: 64];
        mRr = (w + 1) % 3;
      end
    end
  end

  always @(negedge clk) begin : compare
    int w;
    logic [2:0] expReady;
    w = arst_ni ? winnerOf(cmpValid, mRr) : -1;
    expReady = (w >= 0) ? 3'(1 << w) : 3'b000;
    checkOutput("ready", 64'(cmp_ready_o), 64'(expReady));
`ifdef RV_WB_ARB_BYPASS_EN
    checkOutput("wr_en", 64'(wr_en_o), 64'(w >= 0));
    if (w >= 0) begin
      checkOutput("wr_addr", 64'(wr_addr_o), 64'(cmpAddr[w*6 +: 6]));
      checkOutput("wr_data", wr_data_o, cmpData[w*64 +: 64]);
    end
`else
    checkOutput("wr_en", 64'(wr_en_o), 64'(mWrEn));
    checkOutput("wr_addr", 64'(wr_addr_o), 64'(mWrAddr));
    checkOutput("wr_data", wr_data_o, mWrData);
`endif
    checkOutput("busy", 64'(busy_cnt_o), 64'(mBusy));
  end

  task automatic applyStimulus(input logic [2:0] v, input logic [5:0] a0, a1, a2,
                               input logic [63:0] d0, d1, d2);
    @(posedge clk);
    #1;
    cmpValid = v;
    cmpAddr  = {a2, a1, a0};
    cmpData  = {d2, d1, d0};
    @(negedge clk);
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    arst_ni = 1'b0;
    cmpValid = '0;
    #1;
    checkOutput("rst_busy", 64'(busy_cnt_o), 64'd0);
    checkOutput("rst_wren", 64'(wr_en_o), 64'd0);
    @(posedge clk);
    #1;
    arst_ni = 1'b1;
  endtask

  task automatic checkWrite(input string name, input logic [5:0] a, input logic [63:0] d);
`ifndef RV_WB_ARB_BYPASS_EN
    checkOutput({name, "_en"}, 64'(wr_en_o), 64'd1);
    checkOutput({name, "_addr"}, 64'(wr_addr_o), 64'(a));
    checkOutput({name, "_data"}, wr_data_o, d);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    arst_ni = 1'b1;
    @(negedge clk);
    checkOutput("init_busy", 64'(busy_cnt_o), 64'd0);
    checkOutput("init_wren", 64'(wr_en_o), 64'd0);

    // Single port.
    applyStimulus(3'b010, 6'h00, 6'h05, 6'h00, 64'h0, 64'hDEAD, 64'h0);
    checkOutput("single_ready", 64'(cmp_ready_o), 64'b010);
    applyStimulus(3'b000, 6'h00, 6'h05, 6'h00, 64'h0, 64'hDEAD, 64'h0);
    checkWrite("single_wr", 6'h05, 64'hDEAD);
    applyStimulus(3'b110, 6'h00, 6'h06, 6'h07, 64'h0, 64'h11, 64'h22);
    checkOutput("rr2_ready", 64'(cmp_ready_o), 64'b100);
    applyStimulus(3'b010, 6'h00, 6'h06, 6'h07, 64'h0, 64'h11, 64'h22);
    checkOutput("rr0_ready", 64'(cmp_ready_o), 64'b010);
    applyStimulus(3'b000, 6'h00, 6'h06, 6'h07, 64'h0, 64'h11, 64'h22);
    checkWrite("p1_wr", 6'h06, 64'h11);
    checkOutput("busy_one", 64'(busy_cnt_o), 64'd1);

    // Full contention from reset.
    resetDut();
    applyStimulus(3'b111, 6'h01, 6'h02, 6'h03, 64'hA0, 64'hA1, 64'hA2);
    checkOutput("cont_g0", 64'(cmp_ready_o), 64'b001);
    applyStimulus(3'b111, 6'h01, 6'h02, 6'h03, 64'hA0, 64'hA1, 64'hA2);
    checkOutput("cont_g1", 64'(cmp_ready_o), 64'b010);
    checkWrite("cont_w0", 6'h01, 64'hA0);
    applyStimulus(3'b111, 6'h01, 6'h02, 6'h03, 64'hA0, 64'hA1, 64'hA2);
    checkOutput("cont_g2", 64'(cmp_ready_o), 64'b100);
    applyStimulus(3'b000, 6'h01, 6'h02, 6'h03, 64'hA0, 64'hA1, 64'hA2);
    checkOutput("cont_busy", 64'(busy_cnt_o), 64'd3);
    checkWrite("cont_w2", 6'h03, 64'hA2);

    // Wrap-around from pointer 2.
    applyStimulus(3'b010, 6'h00, 6'h09, 6'h00, 64'h0, 64'h99, 64'h0);
    checkOutput("wrap_pre", 64'(cmp_ready_o), 64'b010);
    applyStimulus(3'b011, 6'h0A, 6'h0B, 6'h00, 64'hAA, 64'hBB, 64'h0);
    checkOutput("wrap_p0", 64'(cmp_ready_o), 64'b001);
    applyStimulus(3'b010, 6'h0A, 6'h0B, 6'h00, 64'hAA, 64'hBB, 64'h0);
    checkOutput("wrap_p1", 64'(cmp_ready_o), 64'b010);
    applyStimulus(3'b000, 6'h0A, 6'h0B, 6'h00, 64'hAA, 64'hBB, 64'h0);
    checkWrite("wrap_wr", 6'h0B, 64'hBB);
    checkOutput("wrap_busy", 64'(busy_cnt_o), 64'd4);

    // FP destination and x0.
    applyStimulus(3'b100, 6'h00, 6'h00, 6'h23, 64'h0, 64'h0, 64'h3F800000);
    checkOutput("fp_ready", 64'(cmp_ready_o), 64'b100);
    applyStimulus(3'b001, 6'h00, 6'h00, 6'h23, 64'h1234, 64'h0, 64'h3F800000);
    checkWrite("fp_wr", 6'h23, 64'h3F800000);
    applyStimulus(3'b000, 6'h00, 6'h00, 6'h23, 64'h1234, 64'h0, 64'h3F800000);
    checkWrite("x0_wr", 6'h00, 64'h1234);

    // Reset while port 0 is being granted.
    applyStimulus(3'b001, 6'h11, 6'h00, 6'h00, 64'h55, 64'h0, 64'h0);
    checkOutput("rstx_ready", 64'(cmp_ready_o), 64'b001);
    #2;
    arst_ni = 1'b0;
    #1;
    checkOutput("rstx_ready0", 64'(cmp_ready_o), 64'b000);
    checkOutput("rstx_wren0", 64'(wr_en_o), 64'd0);
    checkOutput("rstx_busy0", 64'(busy_cnt_o), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rstx_wren1", 64'(wr_en_o), 64'd0);
    @(posedge clk);
    #1;
    cmpValid = '0;
    arst_ni = 1'b1;
    applyStimulus(3'b000, 6'h11, 6'h00, 6'h00, 64'h55, 64'h0, 64'h0);
    checkOutput("rstx_wren2", 64'(wr_en_o), 64'd0);
    checkOutput("rstx_busy2", 64'(busy_cnt_o), 64'd0);
    applyStimulus(3'b011, 6'h01, 6'h02, 6'h00, 64'h71, 64'h72, 64'h0);
    checkOutput("rstx_rr0", 64'(cmp_ready_o), 64'b001);
    applyStimulus(3'b000, 6'h01, 6'h02, 6'h00, 64'h71, 64'h72, 64'h0);
    checkWrite("rstx_wr", 6'h01, 64'h71);

    // Saturation under permanent two-port contention.
    resetDut();
    applyStimulus(3'b011, 6'h04, 6'h08, 6'h00, 64'h44, 64'h88, 64'h0);
    repeat (65600) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_max", 64'(busy_cnt_o), 64'hFFFF);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_hold", 64'(busy_cnt_o), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
